// File: rtl/pwm_fade_multi.sv
// pwm_fade_multi: multi-channel PWM fade engine with one shared period counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start, stop  one-cycle pulses; start validates and latches config, stop returns to IDLE
//   mode         0 static, 1 breathe, 2 one-shot ramp-and-hold, 3 static
//   period, duty_min, duty_max, step, fade_div, phase_ofs  configuration, sampled on start only
//   pwm_out      registered PWM outputs, one per channel
//   busy         high in RUN or HOLD
//   done         one-cycle pulse on the wrap where one-shot reaches duty_max on every channel
//   cfg_err      sticky flag for a rejected start, cleared by a valid start
//   cnt_wrap     high during the last count of each period
module pwm_fade_multi #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty_min,
  input  logic [CNT_W-1:0] duty_max,
  input  logic [CNT_W-1:0] step,
  input  logic [DIV_W-1:0] fade_div,
  input  logic [CNT_W-1:0] phase_ofs,
  output logic [N_CH-1:0]  pwm_out,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             cnt_wrap
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam int EW = CNT_W + $clog2(N_CH) + 1;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt, r_period, r_min, r_max, r_step;
  logic [DIV_W-1:0] r_div, r_fdiv;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_duty [N_CH];
  logic [N_CH-1:0]  r_dir, r_pwm;
  logic             r_cfg_err;
  logic [CNT_W-1:0] w_nduty [N_CH];
  logic [CNT_W-1:0] w_init [N_CH];
  logic [N_CH-1:0]  w_ndir, w_init_dn, w_at_max;
  logic             w_busy, w_wrap, w_fade, w_valid;
  assign w_busy  = r_state != IDLE;
  assign w_wrap  = w_busy && (r_cnt == r_period - 1'b1);
  assign w_fade  = w_wrap && r_state == RUN && (r_mode == 2'd1 || r_mode == 2'd2) &&
                   (r_fdiv == '0 || r_div == r_fdiv - 1'b1);
  assign w_valid = period != '0 && duty_min <= duty_max;
  genvar k;
  generate
    for (k = 0; k < N_CH; k++) begin : g_ch
      logic [CNT_W:0] w_up_sum, w_dn_lim;
      logic [EW-1:0]  w_sum;
      logic           w_up_hit, w_dn_hit, w_down;
      assign w_up_sum    = {1'b0, r_duty[k]} + {1'b0, r_step};
      assign w_dn_lim    = {1'b0, r_min} + {1'b0, r_step};
      assign w_up_hit    = w_up_sum >= {1'b0, r_max};
      assign w_dn_hit    = {1'b0, r_duty[k]} <= w_dn_lim;
      // one-shot always applies the up rule even if the channel started at duty_max
      assign w_down      = r_dir[k] && r_mode == 2'd1;
      assign w_nduty[k]  = w_down ? (w_dn_hit ? r_min : r_duty[k] - r_step)
                                  : (w_up_hit ? r_max : w_up_sum[CNT_W-1:0]);
      assign w_ndir[k]   = w_down ? !w_dn_hit : w_up_hit;
      assign w_at_max[k] = w_nduty[k] == r_max;
      // widened so the stagger sum cannot wrap before it is clamped to duty_max
      assign w_sum        = EW'(duty_min) + EW'(phase_ofs) * EW'(k);
      assign w_init_dn[k] = w_sum >= EW'(duty_max);
      assign w_init[k]    = w_init_dn[k] ? duty_max : w_sum[CNT_W-1:0];
    end
  endgenerate
  assign pwm_out  = r_pwm;
  assign busy     = w_busy;
  assign cfg_err  = r_cfg_err;
  assign cnt_wrap = w_wrap;
  assign done     = w_fade && r_mode == 2'd2 && &w_at_max;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_period  <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_step    <= '0;
      r_fdiv    <= '0;
      r_mode    <= '0;
      r_dir     <= '0;
      r_pwm     <= '0;
      r_cfg_err <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_duty[i] <= '0;
    end else if (stop) begin
      r_state <= IDLE;
      r_pwm   <= '0;
    end else if (start && w_valid) begin
      r_state   <= RUN;
      r_cnt     <= '0;
      r_div     <= '0;
      r_period  <= period;
      r_min     <= duty_min;
      r_max     <= duty_max;
      r_step    <= step;
      r_fdiv    <= fade_div;
      r_mode    <= mode;
      r_dir     <= w_init_dn;
      r_pwm     <= '0;
      r_cfg_err <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_duty[i] <= w_init[i];
    end else begin
      if (start) r_cfg_err <= 1'b1;
      if (w_busy) begin
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        for (int i = 0; i < N_CH; i++) r_pwm[i] <= r_cnt < r_duty[i];
        if (w_wrap) r_div <= (r_fdiv == '0 || r_div == r_fdiv - 1'b1) ? '0 : r_div + 1'b1;
        if (w_fade) begin
          r_dir <= w_ndir;
          for (int i = 0; i < N_CH; i++) r_duty[i] <= w_nduty[i];
          if (r_mode == 2'd2 && &w_at_max) r_state <= HOLD;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_fade_multi.sv
// tb_pwm_fade_multi: directed checks of pwm_fade_multi with two channels.
module tb_pwm_fade_multi;
  localparam int N = 2, CW = 16, DW = 8;
  logic          clk = 0, rst_n = 0, start = 0, stop = 0;
  logic [1:0]    mode = 0;
  logic [CW-1:0] period = 0, duty_min = 0, duty_max = 0, step = 0, phase_ofs = 0;
  logic [DW-1:0] fade_div = 0;
  logic [N-1:0]  pwm_out;
  logic          busy, done, cfg_err, cnt_wrap;
  int            checks = 0, errors = 0;
  logic [9:0]    v0, v1;
  int            nw, nd, ones;
  int            bexp [8] = '{0, 2, 4, 6, 4, 2, 0, 2};
  int            oexp [9] = '{0, 0, 2, 2, 4, 4, 6, 6, 6};
  always #5 clk = ~clk;
  pwm_fade_multi #(.N_CH(N), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .period(period), .duty_min(duty_min), .duty_max(duty_max), .step(step),
    .fade_div(fade_div), .phase_ofs(phase_ofs), .pwm_out(pwm_out), .busy(busy),
    .done(done), .cfg_err(cfg_err), .cnt_wrap(cnt_wrap)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input logic [1:0] m, input int p, mn, mx, st, fd, of);
    mode = m; period = CW'(p); duty_min = CW'(mn); duty_max = CW'(mx);
    step = CW'(st); fade_div = DW'(fd); phase_ofs = CW'(of);
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  // one sample per clock for ten clocks; bit i of v0/v1 is the channel output at sample i
  task automatic win(output logic [9:0] a, b, output int w, d);
    w = 0; d = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a[i] = pwm_out[0]; b[i] = pwm_out[1];
      w += int'(cnt_wrap); d += int'(done);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_wrap", 32'(cnt_wrap), 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("idle_pwm", 32'(pwm_out), 0);
    chk("idle_busy", 32'(busy), 0);
    // static: ch0 duty 3, ch1 duty 3+4 = 7
    cfg(0, 10, 3, 100, 0, 0, 4);
    pulse_start();
    chk("st_busy", 32'(busy), 1);
    for (int p = 0; p < 2; p++) begin
      win(v0, v1, nw, nd);
      chk($sformatf("st_ch0_p%0d", p), 32'(v0), 32'h007);
      chk($sformatf("st_ch1_p%0d", p), 32'(v1), 32'h07f);
      chk($sformatf("st_wrap_p%0d", p), 32'(nw), 1);
    end
    // asynchronous reset while running
    @(negedge clk);
    chk("pre_rst_pwm", 32'(pwm_out), 32'h3);
    #2 rst_n = 0;
    #1;
    chk("async_rst_pwm", 32'(pwm_out), 0);
    chk("async_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_pwm", 32'(pwm_out), 0);
    chk("post_rst_busy", 32'(busy), 0);
    // breathe: 0,2,4,6,4,2,0,2
    cfg(1, 10, 0, 6, 2, 1, 0);
    pulse_start();
    for (int p = 0; p < 8; p++) begin
      win(v0, v1, nw, nd);
      chk($sformatf("br_ch0_p%0d", p), 32'(v0), 32'((1 << bexp[p]) - 1));
      chk($sformatf("br_ch1_p%0d", p), 32'(v1), 32'((1 << bexp[p]) - 1));
    end
    // one-shot, fade_div 2: 0,0,2,2,4,4,6 then hold
    cfg(2, 10, 0, 6, 2, 2, 0);
    pulse_start();
    for (int p = 0; p < 9; p++) begin
      win(v0, v1, nw, nd);
      chk($sformatf("os_ch0_p%0d", p), 32'(v0), 32'((1 << oexp[p]) - 1));
      chk($sformatf("os_done_p%0d", p), 32'(nd), 32'(p == 5));
    end
    chk("os_hold_busy", 32'(busy), 1);
    // rejected start leaves the static pattern running
    cfg(0, 10, 3, 100, 0, 0, 4);
    pulse_start();
    cfg(1, 4, 8, 5, 1, 1, 0);
    pulse_start();
    chk("bad_cfg_err", 32'(cfg_err), 1);
    chk("bad_busy", 32'(busy), 1);
    win(v0, v1, nw, nd);
    chk("bad_ch0_ones", 32'($countones(v0)), 3);
    chk("bad_ch1_ones", 32'($countones(v1)), 7);
    chk("bad_wrap", 32'(nw), 1);
    cfg(0, 10, 2, 100, 0, 0, 0);
    pulse_start();
    chk("good_cfg_err", 32'(cfg_err), 0);
    win(v0, v1, nw, nd);
    chk("good_ch0", 32'(v0), 32'h003);
    // stop beats start in the same cycle
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_pwm", 32'(pwm_out), 0);
    win(v0, v1, nw, nd);
    chk("stop_idle_pwm", 32'(v0 | v1), 0);
    chk("stop_idle_wrap", 32'(nw), 0);
    // duty beyond period gives constant high
    cfg(0, 5, 9, 9, 0, 0, 0);
    pulse_start();
    win(v0, v1, nw, nd);
    chk("full_ch0", 32'(v0), 32'h3ff);
    chk("full_ch1", 32'(v1), 32'h3ff);
    chk("full_wrap", 32'(nw), 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
